// File: rtl/bcd_score_counter.sv
// Saturating packed-BCD score counter with rising-edge event detect and leading-zero mask.
// Optional decrement input DEC is enabled by defining BCD_SCORE_DEC_EN.
module bcd_score_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  clr_i,
    input  logic                  inc_i,
`ifdef BCD_SCORE_DEC_EN
    input  logic                  dec_i,
`endif
    input  logic [3:0]            add_i,
    output logic [4*DIGITS-1:0]   out_o,
    output logic [DIGITS-1:0]     lz_mask_o,
    output logic                  max_o
);

    localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{4'h9}};

    logic                inc_q;
    logic                inc_edge;
    logic                dec_edge;
    logic [3:0]          add_c;
    logic [4*DIGITS-1:0] out_q, out_d;
    logic                max_q, max_d;
    logic [4*DIGITS-1:0] sum_inc;
    logic                carry_out;

    assign add_c    = (add_i > 4'd9) ? 4'd9 : add_i;
    assign inc_edge = inc_i & ~inc_q;

`ifdef BCD_SCORE_DEC_EN
    logic                dec_q;
    logic [4*DIGITS-1:0] diff_dec;
    logic                borrow_out;

    assign dec_edge = dec_i & ~dec_q;

    always_comb begin
        logic [4:0] need;
        logic [3:0] dig;
        logic       borrow;
        diff_dec = '0;
        borrow   = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            dig  = out_q[4*k +: 4];
            need = ((k == 0) ? {1'b0, add_c} : 5'd0) + {4'b0, borrow};
            if ({1'b0, dig} < need) begin
                diff_dec[4*k +: 4] = 4'({1'b0, dig} + 5'd10 - need);
                borrow             = 1'b1;
            end else begin
                diff_dec[4*k +: 4] = 4'({1'b0, dig} - need);
                borrow             = 1'b0;
            end
        end
        borrow_out = borrow;
    end
`else
    assign dec_edge = 1'b0;
`endif

    // Decimal ripple add; the carry out of the top digit means overflow.
    always_comb begin
        logic [4:0] tmp;
        logic       carry;
        sum_inc = '0;
        carry   = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            tmp = {1'b0, out_q[4*k +: 4]} + {4'b0, carry}
                + ((k == 0) ? {1'b0, add_c} : 5'd0);
            if (tmp > 5'd9) begin
                sum_inc[4*k +: 4] = 4'(tmp - 5'd10);
                carry             = 1'b1;
            end else begin
                sum_inc[4*k +: 4] = tmp[3:0];
                carry             = 1'b0;
            end
        end
        carry_out = carry;
    end

    always_comb begin
        out_d = out_q;
        max_d = max_q;
        if (clr_i) begin
            out_d = '0;
            max_d = 1'b0;
        end else if (inc_edge && !dec_edge) begin
            if (carry_out) begin
                out_d = AllNines;
                max_d = 1'b1;
            end else begin
                out_d = sum_inc;
            end
`ifdef BCD_SCORE_DEC_EN
        end else if (dec_edge && !inc_edge && (add_c != 4'd0)) begin
            out_d = borrow_out ? '0 : diff_dec;
            max_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            out_q <= '0;
            max_q <= 1'b0;
            inc_q <= 1'b1;
`ifdef BCD_SCORE_DEC_EN
            dec_q <= 1'b1;
`endif
        end else begin
            out_q <= out_d;
            max_q <= max_d;
            inc_q <= inc_i;
`ifdef BCD_SCORE_DEC_EN
            dec_q <= dec_i;
`endif
        end
    end

    // Derived only from registered digits, so no path from the event inputs.
    always_comb begin
        logic nz;
        lz_mask_o = '0;
        nz        = 1'b0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            nz           = nz | (out_q[4*k +: 4] != 4'd0);
            lz_mask_o[k] = ~nz;
        end
    end

    assign out_o = out_q;
    assign max_o = max_q;

endmodule
